// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions for the memory access stage.
// Holds the RV32I load/store funct3 encodings, the stage FSM state type,
// the bubble destination constant and small decode helpers.
package mem_access_stage_pkg;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  // rd = x0 never writes, so WB treats it as an empty slot.
  localparam logic [4:0] BubbleRd = 5'd0;

  typedef enum logic {StIdle, StBusy} state_e;

  function automatic logic f3_illegal(logic is_load, logic [2:0] f3);
    if (is_load) begin
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    return !((f3 == F3Sb) || (f3 == F3Sh) || (f3 == F3Sw));
  endfunction

  // f3[1:0] is the access size for both loads and stores (01 half, 10 word).
  function automatic logic misaligned(logic [1:0] size, logic [1:0] addr_lo);
    if (size == 2'b01) begin
      return addr_lo[0];
    end
    if (size == 2'b10) begin
      return addr_lo != 2'b00;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus.
// master: the pipeline stage (drives req/we/be/addr/wdata, receives rdata/ack).
// slave:  the memory (drives rdata/ack).
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_stage_load_align.sv
// load_align: combinational byte/half extraction and sign/zero extension
// of a 32-bit read word.
// Ports: rdata_i (read word), addr_lo_i (byte offset), funct3_i (load type),
//        data_o (write-back value).
module load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    unique case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    unique case (funct3_i)
      F3Lb:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3Lh:    data_o = {{16{half_sel[15]}}, half_sel};
      F3Lbu:   data_o = {24'd0, byte_sel};
      F3Lhu:   data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I MEM stage. Passes ALU results through in one
// cycle, runs a req/ack data-memory transaction for loads and stores
// (stalling upstream while busy), aligns load data and aborts a hung bus.
// Ports: clk/rst (sync active-high); in_* op from EX; flushM kill;
//        stall_req to upstream; dmem bus (master); *_MEM registered result
//        to WB; mem_exc one-cycle exception pulse.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_is_load,
  input  logic                        in_is_store,
  input  logic [2:0]                  in_funct3,
  input  logic [31:0]                 in_addr,
  input  logic [31:0]                 in_store_data,
  input  logic [4:0]                  in_reg_dest,
  input  logic                        in_reg_write,
  input  logic                        flushM,
  output logic                        stall_req,
  mem_access_stage_if.master          dmem,
  output logic [4:0]                  reg_dest_MEM,
  output logic [31:0]                 result_MEM,
  output logic                        reg_write_MEM,
  output logic                        mem_exc
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        discard_q, discard_d;
  logic        lat_load_q, lat_load_d;
  logic [2:0]  lat_funct3_q, lat_funct3_d;
  logic [1:0]  lat_lo_q, lat_lo_d;
  logic [4:0]  lat_rd_q, lat_rd_d;
  logic        lat_rw_q, lat_rw_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;
  logic        rw_q, rw_d;
  logic        exc_q, exc_d;

  logic        in_mem;
  logic        in_bad;
  logic [31:0] load_data;

  assign in_mem = in_is_load | in_is_store;
  assign in_bad = f3_illegal(in_is_load, in_funct3) | misaligned(in_funct3[1:0], in_addr[1:0]);

  load_align u_load_align (
    .rdata_i   (dmem.dmem_rdata),
    .addr_lo_i (lat_lo_q),
    .funct3_i  (lat_funct3_q),
    .data_o    (load_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    discard_d    = discard_q;
    lat_load_d   = lat_load_q;
    lat_funct3_d = lat_funct3_q;
    lat_lo_d     = lat_lo_q;
    lat_rd_d     = lat_rd_q;
    lat_rw_d     = lat_rw_q;
    req_d        = req_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = BubbleRd;
    res_d        = '0;
    rw_d         = 1'b0;
    exc_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid && !flushM) begin
          if (!in_mem) begin
            rd_d  = in_reg_dest;
            res_d = in_addr;
            rw_d  = in_reg_write;
          end else if (in_bad) begin
            exc_d = 1'b1;
          end else begin
            state_d      = StBusy;
            cnt_d        = '0;
            discard_d    = 1'b0;
            lat_load_d   = in_is_load;
            lat_funct3_d = in_funct3;
            lat_lo_d     = in_addr[1:0];
            lat_rd_d     = in_reg_dest;
            lat_rw_d     = in_reg_write;
            req_d        = 1'b1;
            we_d         = in_is_store;
            addr_d       = {in_addr[31:2], 2'b00};
            be_d         = 4'b1111;
            wdata_d      = in_store_data;
            if (in_is_store) begin
              if (in_funct3 == F3Sb) begin
                be_d    = 4'b0001 << in_addr[1:0];
                wdata_d = {4{in_store_data[7:0]}};
              end else if (in_funct3 == F3Sh) begin
                be_d    = in_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{in_store_data[15:0]}};
              end
            end
          end
        end
      end
      StBusy: begin
        // A flushed transaction must still finish: a store cannot be recalled.
        if (flushM) begin
          discard_d = 1'b1;
        end
        if (dmem.dmem_ack) begin
          state_d = StIdle;
          req_d   = 1'b0;
          if (lat_load_q && !discard_q && !flushM) begin
            rd_d  = lat_rd_q;
            res_d = load_data;
            rw_d  = lat_rw_q;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d = StIdle;
          req_d   = 1'b0;
          exc_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      discard_q    <= 1'b0;
      lat_load_q   <= 1'b0;
      lat_funct3_q <= '0;
      lat_lo_q     <= '0;
      lat_rd_q     <= '0;
      lat_rw_q     <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= BubbleRd;
      res_q        <= '0;
      rw_q         <= 1'b0;
      exc_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      discard_q    <= discard_d;
      lat_load_q   <= lat_load_d;
      lat_funct3_q <= lat_funct3_d;
      lat_lo_q     <= lat_lo_d;
      lat_rd_q     <= lat_rd_d;
      lat_rw_q     <= lat_rw_d;
      req_q        <= req_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      res_q        <= res_d;
      rw_q         <= rw_d;
      exc_q        <= exc_d;
    end
  end

  assign stall_req       = (state_q == StBusy);
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign reg_dest_MEM    = rd_q;
  assign result_MEM      = res_q;
  assign reg_write_MEM   = rw_q;
  assign mem_exc         = exc_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT_CYCLES = 4).
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_store_data;
  logic [4:0]  in_reg_dest;
  logic        in_reg_write;
  logic        flushM;
  logic        stall_req;
  logic [4:0]  reg_dest_MEM;
  logic [31:0] result_MEM;
  logic        reg_write_MEM;
  logic        mem_exc;

  int checks;
  int failures;
  int stalls;

  mem_access_stage_if mif ();

  mem_access_stage #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_is_load    (in_is_load),
    .in_is_store   (in_is_store),
    .in_funct3     (in_funct3),
    .in_addr       (in_addr),
    .in_store_data (in_store_data),
    .in_reg_dest   (in_reg_dest),
    .in_reg_write  (in_reg_write),
    .flushM        (flushM),
    .stall_req     (stall_req),
    .dmem          (mif),
    .reg_dest_MEM  (reg_dest_MEM),
    .result_MEM    (result_MEM),
    .reg_write_MEM (reg_write_MEM),
    .mem_exc       (mem_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic ld, input logic st, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] data,
                    input logic [4:0] rd, input logic rw);
    in_valid      = 1'b1;
    in_is_load    = ld;
    in_is_store   = st;
    in_funct3     = f3;
    in_addr       = addr;
    in_store_data = data;
    in_reg_dest   = rd;
    in_reg_write  = rw;
  endtask

  task automatic idle_in();
    in_valid    = 1'b0;
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
  endtask

  // Called just after the accepting edge. Acks after `waits` busy cycles
  // (negative = never) and counts busy cycles; returns just after the
  // edge that ends the transaction.
  task automatic mem_run(input int waits, input logic [31:0] rdata, output int n);
    bit done;
    n    = 0;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (stall_req) n++;
      if (k == waits) begin
        mif.dmem_ack   = 1'b1;
        mif.dmem_rdata = rdata;
      end
      tick();
      mif.dmem_ack   = 1'b0;
      mif.dmem_rdata = 32'h0;
      if (!stall_req) done = 1;
    end
    if (!done) chk("busy_bound", 32'd1, 32'd0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    flushM        = 1'b0;
    in_funct3     = 3'b000;
    in_addr       = 32'h0;
    in_store_data = 32'h0;
    in_reg_dest   = 5'd0;
    in_reg_write  = 1'b0;
    idle_in();
    mif.dmem_ack   = 1'b0;
    mif.dmem_rdata = 32'h0;
    tick();
    tick();
    chk("rst_stall", stall_req, 0);
    chk("rst_req", mif.dmem_req, 0);
    chk("rst_addr", mif.dmem_addr, 0);
    chk("rst_be", mif.dmem_be, 0);
    chk("rst_rd", reg_dest_MEM, 0);
    chk("rst_res", result_MEM, 0);
    chk("rst_exc", mem_exc, 0);
    rst = 1'b0;
    tick();

    // ALU pass-through, back to back.
    op(0, 0, 3'b000, 32'h1234, 32'h0, 5'd5, 1);
    chk("alu_nostall", stall_req, 0);
    tick();
    chk("alu_rd", reg_dest_MEM, 5);
    chk("alu_res", result_MEM, 32'h1234);
    chk("alu_rw", reg_write_MEM, 1);
    op(0, 0, 3'b000, 32'hDEAD_BEEF, 32'h0, 5'd7, 0);
    tick();
    chk("alu2_rd", reg_dest_MEM, 7);
    chk("alu2_res", result_MEM, 32'hDEAD_BEEF);
    chk("alu2_rw", reg_write_MEM, 0);
    idle_in();
    tick();
    chk("idle_bubble", reg_dest_MEM, 0);

    // LB at 0x103, two wait cycles.
    op(1, 0, 3'b000, 32'h103, 32'h0, 5'd9, 1);
    tick();
    idle_in();
    chk("lb_req", mif.dmem_req, 1);
    chk("lb_addr", mif.dmem_addr, 32'h100);
    chk("lb_we", mif.dmem_we, 0);
    chk("lb_be", mif.dmem_be, 4'hF);
    chk("lb_bubble", reg_dest_MEM, 0);
    mem_run(2, 32'h80FF_0000, stalls);
    chk("lb_stalls", stalls, 3);
    chk("lb_res", result_MEM, 32'hFFFF_FF80);
    chk("lb_rd", reg_dest_MEM, 9);
    chk("lb_rw", reg_write_MEM, 1);
    chk("lb_req_drop", mif.dmem_req, 0);

    // LHU at 0x202, one wait cycle.
    op(1, 0, 3'b101, 32'h202, 32'h0, 5'd10, 1);
    tick();
    idle_in();
    mem_run(1, 32'h8765_4321, stalls);
    chk("lhu_stalls", stalls, 2);
    chk("lhu_res", result_MEM, 32'h0000_8765);

    // LH at 0x0, zero wait.
    op(1, 0, 3'b001, 32'h0, 32'h0, 5'd11, 1);
    tick();
    idle_in();
    mem_run(0, 32'h0000_8001, stalls);
    chk("lh_res", result_MEM, 32'hFFFF_8001);

    // SH at 0x102, zero wait; an ALU op held upstream during the stall.
    op(0, 1, 3'b001, 32'h102, 32'hABCD_1234, 5'd0, 0);
    tick();
    chk("sh_be", mif.dmem_be, 4'b1100);
    chk("sh_wdata", mif.dmem_wdata, 32'h1234_1234);
    chk("sh_we", mif.dmem_we, 1);
    op(0, 0, 3'b000, 32'h66, 32'h0, 5'd6, 1);
    mem_run(0, 32'h0, stalls);
    chk("sh_stalls", stalls, 1);
    chk("sh_bubble_rd", reg_dest_MEM, 0);
    chk("sh_bubble_rw", reg_write_MEM, 0);
    tick();
    idle_in();
    chk("held_alu_rd", reg_dest_MEM, 6);
    chk("held_alu_res", result_MEM, 32'h66);

    // SB at 0x101 lane check.
    op(0, 1, 3'b000, 32'h101, 32'h0000_00A5, 5'd0, 0);
    tick();
    idle_in();
    chk("sb_be", mif.dmem_be, 4'b0010);
    chk("sb_wdata", mif.dmem_wdata, 32'hA5A5_A5A5);
    mem_run(0, 32'h0, stalls);

    // Misaligned LW.
    op(1, 0, 3'b010, 32'h101, 32'h0, 5'd3, 1);
    tick();
    idle_in();
    chk("mis_req", mif.dmem_req, 0);
    chk("mis_exc", mem_exc, 1);
    chk("mis_rw", reg_write_MEM, 0);
    chk("mis_stall", stall_req, 0);
    tick();
    chk("mis_exc_pulse", mem_exc, 0);

    // Illegal store funct3.
    op(0, 1, 3'b011, 32'h100, 32'h0, 5'd0, 0);
    tick();
    idle_in();
    chk("ill_exc", mem_exc, 1);
    chk("ill_req", mif.dmem_req, 0);

    // Timeout after 4 busy cycles.
    op(1, 0, 3'b010, 32'h200, 32'h0, 5'd12, 1);
    tick();
    idle_in();
    mem_run(-1, 32'h0, stalls);
    chk("to_stalls", stalls, 4);
    chk("to_exc", mem_exc, 1);
    chk("to_req", mif.dmem_req, 0);
    chk("to_rd", reg_dest_MEM, 0);
    tick();
    chk("to_exc_pulse", mem_exc, 0);

    // Flush during a busy load, ack later.
    op(1, 0, 3'b010, 32'h300, 32'h0, 5'd4, 1);
    tick();
    idle_in();
    flushM = 1'b1;
    tick();
    flushM = 1'b0;
    mem_run(0, 32'h1111_2222, stalls);
    chk("fl_rd", reg_dest_MEM, 0);
    chk("fl_rw", reg_write_MEM, 0);
    chk("fl_res", result_MEM, 0);

    // Flush and ack in the same busy cycle.
    op(1, 0, 3'b010, 32'h304, 32'h0, 5'd8, 1);
    tick();
    idle_in();
    flushM         = 1'b1;
    mif.dmem_ack   = 1'b1;
    mif.dmem_rdata = 32'h3333_4444;
    tick();
    flushM         = 1'b0;
    mif.dmem_ack   = 1'b0;
    chk("flack_stall", stall_req, 0);
    chk("flack_rw", reg_write_MEM, 0);
    chk("flack_rd", reg_dest_MEM, 0);

    // Flush in IDLE kills an ALU op.
    op(0, 0, 3'b000, 32'h55, 32'h0, 5'd13, 1);
    flushM = 1'b1;
    tick();
    flushM = 1'b0;
    idle_in();
    chk("flidle_rd", reg_dest_MEM, 0);
    chk("flidle_rw", reg_write_MEM, 0);

    // Reset during BUSY.
    op(1, 0, 3'b010, 32'h400, 32'h0, 5'd14, 1);
    tick();
    idle_in();
    tick();
    chk("rb_busy", stall_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb_req", mif.dmem_req, 0);
    chk("rb_stall", stall_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
